// File: rtl/sfm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sfm_pkg
//  Description : Shared types and constants for the softmax streamer blocks.
//  Revision    : 1.0
// ============================================================================
package sfm_pkg;

    localparam int unsigned SFM_DATA_W = 288;
    localparam logic [15:0] SFM_PAD_FP16_NINF = 16'hFC00;

    typedef enum logic [1:0] {
        LP_IDLE = 2'd0,
        LP_RUN  = 2'd1,
        LP_LAST = 2'd2
    } sfm_lftovr_pad_state_t;

    typedef struct packed {
        logic [31:0] tot_len;
        logic [31:0] d0_len;
    } sfm_addressgen_ctrl_t;

    typedef struct packed {
        sfm_addressgen_ctrl_t addressgen_ctrl;
    } hci_streamer_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/sfm_lftovr_mask_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sfm_lftovr_mask_gen
//  Description : Maps a leftover byte count to a byte mask (bit i set if i < lftovr).
//  Revision    : 1.0
// ============================================================================
module sfm_lftovr_mask_gen #(
    parameter int unsigned NB = 32,
    parameter int unsigned LW = 5
) (
    input  logic [LW-1:0] lftovr_i,
    output logic [NB-1:0] mask_o
);

    for (genvar i = 0; i < NB; i++) begin : g_mask
        localparam logic [LW-1:0] c_IDX = LW'(i);
        assign mask_o[i] = (lftovr_i > c_IDX);
    end

endmodule
`default_nettype wire

// File: rtl/sfm_streamer_lftovr_pad.sv
`default_nettype none
// ============================================================================
//  Module      : sfm_streamer_lftovr_pad
//  Description : Load-stream beat counter that pads bytes beyond the leftover of
//                the final beat with a neutral element and pulses done.
//                Optional strobe checker: define SFM_LFTOVR_STRB_CHK_EN.
//  Revision    : 1.0
// ============================================================================
module sfm_streamer_lftovr_pad
    import sfm_pkg::*;
#(
    parameter int unsigned        DW      = SFM_DATA_W,
    parameter int unsigned        ELEM_W  = 16,
    parameter logic [ELEM_W-1:0]  PAD_VAL = SFM_PAD_FP16_NINF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    input  hci_streamer_ctrl_t  stream_ctrl_i,
    input  logic                stream_i_valid,
    output logic                stream_i_ready,
    input  logic [DW-1:0]       stream_i_data,
    input  logic [DW/8-1:0]     stream_i_strb,
    output logic                stream_o_valid,
    input  logic                stream_o_ready,
    output logic [DW-1:0]       stream_o_data,
    output logic [DW/8-1:0]     stream_o_strb,
    output logic                busy_o,
    output logic                done_o,
    output logic                strb_err_o
);

    localparam int unsigned c_ACTUAL_DW = DW - 32;
    localparam int unsigned c_NB        = c_ACTUAL_DW / 8;
    localparam int unsigned c_EB        = ELEM_W / 8;
    localparam int unsigned c_LW        = $clog2(c_NB);

    sfm_lftovr_pad_state_t r_state, w_state_nxt;
    logic [31:0]            r_cnt;
    logic                   r_out_valid;
    logic [c_ACTUAL_DW-1:0] r_data;

    logic [31:0]            w_tot_len;
    logic [c_LW-1:0]        w_lftovr;
    logic                   w_is_lftovr;
    logic                   w_len_nz;
    logic                   w_last_in;
    logic                   w_pad_en;
    logic                   w_hs_in;
    logic                   w_hs_out;
    logic [c_NB-1:0]        w_mask;
    logic [c_ACTUAL_DW-1:0] w_pad_data;

    assign w_tot_len   = stream_ctrl_i.addressgen_ctrl.tot_len;
    assign w_lftovr    = stream_ctrl_i.addressgen_ctrl.d0_len[c_LW-1:0];
    assign w_is_lftovr = |w_lftovr;
    assign w_len_nz    = |w_tot_len;
    // With tot_len==0 the compare target wraps to all-ones, which cnt never reaches.
    assign w_last_in   = (r_cnt == (w_tot_len - 32'd1));
    assign w_pad_en    = w_last_in & w_is_lftovr;

    assign stream_i_ready = (~r_out_valid | stream_o_ready) & (r_state != LP_LAST);
    assign w_hs_in        = stream_i_valid & stream_i_ready;
    assign w_hs_out       = r_out_valid & stream_o_ready;

    sfm_lftovr_mask_gen #(
        .NB (c_NB),
        .LW (c_LW)
    ) u_mask_gen (
        .lftovr_i (w_lftovr),
        .mask_o   (w_mask)
    );

    for (genvar i = 0; i < c_NB; i++) begin : g_pad
        assign w_pad_data[i*8 +: 8] = (w_pad_en & ~w_mask[i]) ? PAD_VAL[(i % c_EB)*8 +: 8]
                                                              : stream_i_data[i*8 +: 8];
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LP_IDLE: if (w_hs_in & w_len_nz) w_state_nxt = w_last_in ? LP_LAST : LP_RUN;
            LP_RUN:  if (w_hs_in & w_last_in) w_state_nxt = LP_LAST;
            LP_LAST: if (w_hs_out) w_state_nxt = LP_IDLE;
            default: w_state_nxt = LP_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i | clear_i) begin
            r_state     <= LP_IDLE;
            r_cnt       <= 32'd0;
            r_out_valid <= 1'b0;
            r_data      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == LP_LAST) & w_hs_out) begin
                r_cnt <= 32'd0;
            end else if (w_hs_in & w_len_nz) begin
                r_cnt <= r_cnt + 32'd1;
            end
            if (w_hs_in) begin
                r_out_valid <= 1'b1;
                r_data      <= w_pad_data;
            end else if (w_hs_out) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign stream_o_valid = r_out_valid;
    assign stream_o_data  = {32'b0, r_data};
    assign stream_o_strb  = {{(DW/8 - c_NB){1'b0}}, {c_NB{1'b1}}};
    assign busy_o         = (r_state != LP_IDLE);
    assign done_o         = (r_state == LP_LAST) & w_hs_out;

`ifdef SFM_LFTOVR_STRB_CHK_EN
    logic [c_NB-1:0] w_strb_exp;
    logic            r_strb_err;
    logic            w_unused;

    assign w_strb_exp = w_pad_en ? w_mask : {c_NB{1'b1}};

    always_ff @(posedge clk_i) begin
        if (rst_i | clear_i) begin
            r_strb_err <= 1'b0;
        end else if (w_hs_in & (stream_i_strb[c_NB-1:0] != w_strb_exp)) begin
            r_strb_err <= 1'b1;
        end
    end

    assign strb_err_o = r_strb_err;
    assign w_unused   = ^{stream_i_data[DW-1:c_ACTUAL_DW], stream_i_strb[DW/8-1:c_NB],
                          stream_ctrl_i.addressgen_ctrl.d0_len[31:c_LW]};
`else
    logic w_unused;

    assign strb_err_o = 1'b0;
    assign w_unused   = ^{stream_i_data[DW-1:c_ACTUAL_DW], stream_i_strb,
                          stream_ctrl_i.addressgen_ctrl.d0_len[31:c_LW]};
`endif

endmodule
`default_nettype wire

// File: tb/tb_sfm_streamer_lftovr_pad.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sfm_streamer_lftovr_pad
//  Description : Directed bench with a beat-queue model for the leftover padder.
//  Revision    : 1.0
// ============================================================================
module tb_sfm_streamer_lftovr_pad;
    import sfm_pkg::*;

    localparam int DW  = 288;
    localparam int NB  = 32;
    localparam int NBA = DW / 8;

    logic               clk;
    logic               rst_i;
    logic               clear_i;
    hci_streamer_ctrl_t ctrl;
    logic               stream_i_valid;
    logic               stream_i_ready;
    logic [DW-1:0]      stream_i_data;
    logic [NBA-1:0]     stream_i_strb;
    logic               stream_o_valid;
    logic               stream_o_ready;
    logic [DW-1:0]      stream_o_data;
    logic [NBA-1:0]     stream_o_strb;
    logic               busy_o;
    logic               done_o;
    logic               strb_err_o;

    sfm_streamer_lftovr_pad dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .clear_i        (clear_i),
        .stream_ctrl_i  (ctrl),
        .stream_i_valid (stream_i_valid),
        .stream_i_ready (stream_i_ready),
        .stream_i_data  (stream_i_data),
        .stream_i_strb  (stream_i_strb),
        .stream_o_valid (stream_o_valid),
        .stream_o_ready (stream_o_ready),
        .stream_o_data  (stream_o_data),
        .stream_o_strb  (stream_o_strb),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .strb_err_o     (strb_err_o)
    );

    typedef struct {
        logic [255:0] data;
        bit           last;
    } exp_t;

    exp_t         q[$];
    int           checks = 0;
    int           errors = 0;
    int           bp_mode = 0;
    bit           wait_done = 0;
    int           done_cnt = 0;
    logic [255:0] last_out = '0;
    bit           prev_stall = 0;
    logic [DW-1:0] prev_data = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output backpressure: 0 = always ready, 1 = random, 2 = stalled
    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0:       stream_o_ready = 1'b1;
            1:       stream_o_ready = 1'($urandom_range(0, 1));
            default: stream_o_ready = 1'b0;
        endcase
    end

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Expected output payload straight from the leftover rule
    function automatic logic [255:0] pad_exp(input logic [255:0] d, input int k, input int tot, input int d0);
        logic [255:0] r;
        int lft;
        r   = d;
        lft = d0 % NB;
        if (tot > 0 && k == tot - 1 && lft != 0)
            for (int b = lft; b < NB; b++) r[b*8 +: 8] = (b % 2 == 0) ? 8'h00 : 8'hFC;
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_i || clear_i) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 288'(stream_o_valid), 288'(1));
                chk("stall_data", stream_o_data, prev_data);
            end
            if (wait_done) chk("in_ready_in_last", 288'(stream_i_ready), 288'(0));
            if (stream_o_valid && stream_o_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", 288'(1), 288'(0));
                end else begin
                    e = q.pop_front();
                    chk("out_data", stream_o_data, {32'b0, e.data});
                    chk("out_strb", 288'(stream_o_strb), 288'({4'b0, {NB{1'b1}}}));
                    chk("done_on_beat", 288'(done_o), 288'(e.last));
                    last_out = stream_o_data[255:0];
                    if (done_o) begin
                        done_cnt++;
                        wait_done = 0;
                    end
                end
            end else begin
                chk("done_idle", 288'(done_o), 288'(0));
            end
            prev_stall = stream_o_valid && !stream_o_ready;
            prev_data  = stream_o_data;
        end
    end

    task automatic send_load(input int tot, input int d0, input int nbeats, input bit bad_strb);
        logic [255:0] d;
        logic [NB-1:0] s;
        int lft;
        int n;
        exp_t e;
        ctrl.addressgen_ctrl.tot_len = 32'(tot);
        ctrl.addressgen_ctrl.d0_len  = 32'(d0);
        lft = d0 % NB;
        for (int k = 0; k < nbeats; k++) begin
            for (int b = 0; b < NB; b++) d[b*8 +: 8] = 8'(k * 64 + b);
            s = '1;
            if (tot > 0 && k == tot - 1 && lft != 0 && !bad_strb)
                for (int b = 0; b < NB; b++) s[b] = (b < lft);
            stream_i_data  = {32'hDEADBEEF, d};
            stream_i_strb  = {4'hF, s};
            stream_i_valid = 1'b1;
            n = 0;
            forever begin
                @(negedge clk);
                if (stream_i_ready) break;
                n++;
                if (n > 500) break;
            end
            if (n > 500) begin
                chk("in_handshake_timeout", 288'(0), 288'(1));
                stream_i_valid = 1'b0;
                return;
            end
            @(posedge clk);
            e.data = pad_exp(d, k, tot, d0);
            e.last = (tot > 0 && k == tot - 1);
            q.push_back(e);
            if (e.last) wait_done = 1;
            #1;
            stream_i_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0 || wait_done) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk("drain_timeout", 288'(0), 288'(1));
        @(negedge clk);
    endtask

    initial begin
        rst_i          = 1'b1;
        clear_i        = 1'b0;
        stream_i_valid = 1'b0;
        stream_i_data  = '0;
        stream_i_strb  = '0;
        stream_o_ready = 1'b1;
        ctrl           = '0;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("rst_valid", 288'(stream_o_valid), 288'(0));
        chk("rst_busy", 288'(busy_o), 288'(0));
        chk("rst_done", 288'(done_o), 288'(0));
        chk("rst_err", 288'(strb_err_o), 288'(0));
        chk("rst_data", stream_o_data, 288'(0));
        chk("rst_in_ready", 288'(stream_i_ready), 288'(1));

        // Leftover 4 on beat 3
        done_cnt = 0;
        @(posedge clk); #1;
        send_load(4, 100, 4, 0);
        wait_idle();
        chk("t1_done_cnt", 288'(done_cnt), 288'(1));
        chk("t1_keep", 288'(last_out[31:0]), 288'(32'hC3C2C1C0));
        chk("t1_pad_top", 288'(last_out[255:224]), 288'(32'hFC00FC00));
        chk("t1_busy", 288'(busy_o), 288'(0));
        chk("t1_err", 288'(strb_err_o), 288'(0));

        // No leftover: bit-exact passthrough
        done_cnt = 0;
        @(posedge clk); #1;
        send_load(4, 128, 4, 0);
        wait_idle();
        chk("t2_done_cnt", 288'(done_cnt), 288'(1));
        chk("t2_top", 288'(last_out[255:224]), 288'(32'hDFDEDDDC));

        // Random backpressure
        done_cnt = 0;
        bp_mode  = 1;
        @(posedge clk); #1;
        send_load(7, 37, 7, 0);
        wait_idle();
        bp_mode = 0;
        chk("t3_done_cnt", 288'(done_cnt), 288'(1));
        chk("t3_busy", 288'(busy_o), 288'(0));

        // Single-beat load
        done_cnt = 0;
        @(posedge clk); #1;
        send_load(1, 2, 1, 0);
        wait_idle();
        chk("t4_done_cnt", 288'(done_cnt), 288'(1));
        chk("t4_word0", 288'(last_out[31:0]), 288'(32'hFC000100));
        chk("t4_busy", 288'(busy_o), 288'(0));

        // tot_len == 0: passthrough, no done
        done_cnt = 0;
        @(posedge clk); #1;
        send_load(0, 100, 2, 0);
        wait_idle();
        chk("t5_done_cnt", 288'(done_cnt), 288'(0));
        chk("t5_top", 288'(last_out[255:224]), 288'(32'h5F5E5D5C));
        chk("t5_busy", 288'(busy_o), 288'(0));

        // Clear mid-load with a beat held in the output register
        @(posedge clk); #1;
        send_load(7, 100, 3, 0);
        bp_mode        = 2;
        stream_o_ready = 1'b0;
        @(negedge clk);
        chk("t6_busy_pre", 288'(busy_o), 288'(1));
        chk("t6_valid_pre", 288'(stream_o_valid), 288'(1));
        @(posedge clk); #1 clear_i = 1'b1;
        @(posedge clk); #1 clear_i = 1'b0;
        q.delete();
        @(negedge clk);
        chk("t6_valid_post", 288'(stream_o_valid), 288'(0));
        chk("t6_busy_post", 288'(busy_o), 288'(0));
        bp_mode  = 0;
        done_cnt = 0;
        @(posedge clk); #1;
        send_load(4, 100, 4, 0);
        wait_idle();
        chk("t6_done_cnt", 288'(done_cnt), 288'(1));
        chk("t6_keep", 288'(last_out[31:0]), 288'(32'hC3C2C1C0));
        chk("t6_pad_top", 288'(last_out[255:224]), 288'(32'hFC00FC00));

`ifdef SFM_LFTOVR_STRB_CHK_EN
        @(posedge clk); #1;
        send_load(4, 100, 4, 1);
        wait_idle();
        chk("t7_err_set", 288'(strb_err_o), 288'(1));
        chk("t7_pad_top", 288'(last_out[255:224]), 288'(32'hFC00FC00));
        @(posedge clk); #1;
        send_load(4, 100, 4, 0);
        wait_idle();
        chk("t7_err_sticky", 288'(strb_err_o), 288'(1));
`else
        @(posedge clk); #1;
        send_load(4, 100, 4, 1);
        wait_idle();
        chk("t7_err_tied", 288'(strb_err_o), 288'(0));
        chk("t7_pad_top", 288'(last_out[255:224]), 288'(32'hFC00FC00));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
